key_debounce_onehot: RTL and testbench

Conditions the 7 raw push-button inputs into a clean, strictly one-hot key vector for the downstream 7-to-3 encoder. Each button passes through a synchronizer and a per-channel debounce counter. A small lock FSM then selects exactly one held key and holds it until that key is released. Single-cycle press and release strobes go to the control logic alongside the encoded key index.

---
 rtl/key_debounce_onehot_pkg.sv | 19 +
 rtl/key_debounce_onehot_if.sv | 39 +++
 rtl/key_debounce_onehot_btn_debounce.sv | 51 +++++
 rtl/key_debounce_onehot.sv | 109 ++++++++++
 tb/tb_key_debounce_onehot.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_onehot_pkg.sv
// key_debounce_onehot_pkg
// Shared definitions for the push-button conditioner: channel count,
// debounce/synchronizer defaults and the lock FSM state encoding.
// No ports (package).

package key_debounce_onehot_pkg;

  localparam int N_KEYS_DEF      = 7;
  localparam int DB_CYCLES_DEF   = 16;
  // Short debounce window so simulations stay small.
  localparam int DB_CYCLES_SIM   = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

endpackage

// File: rtl/key_debounce_onehot_if.sv
// key_debounce_onehot_if
// Bundles the raw button levels and the conditioned key outputs.
//   btn_raw     : raw bouncy button levels, 1 = pressed
//   key_onehot  : all-zero or exactly one bit set, feeds the 7-to-3 encoder
//   key_valid   : key_onehot is non-zero
//   key_press   : one-cycle pulse when a key is selected
//   key_release : one-cycle pulse when the selected key is dropped
// modport master : the side driving the buttons (board / bench)
// modport slave  : the conditioner itself

interface key_debounce_onehot_if
  import key_debounce_onehot_pkg::*;
#(
  parameter int N_KEYS = N_KEYS_DEF
);

  logic [N_KEYS-1:0] btn_raw;
  logic [N_KEYS-1:0] key_onehot;
  logic              key_valid;
  logic              key_press;
  logic              key_release;

  modport master (
    output btn_raw,
    input  key_onehot,
    input  key_valid,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  btn_raw,
    output key_onehot,
    output key_valid,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_debounce_onehot_btn_debounce.sv
// btn_debounce
// One button channel: SYNC_STAGES-deep synchronizer followed by a debounce
// timer. The debounced level db flips only after DB_CYCLES consecutive
// edges on which the synchronized level differs from db; any shorter
// excursion is dropped and the timer reloaded.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset
//   btn_raw : asynchronous raw level for this channel
//   db      : registered debounced level

module btn_debounce #(
  parameter int DB_CYCLES   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic db
);

  localparam int              CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // cnt_q holds the number of further differing edges still required
  // before db may flip; terminal count is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= CNT_LOAD;
      db     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      if (s == db) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_q == '0) begin
        db    <= s;
        cnt_q <= CNT_LOAD;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_debounce_onehot.sv
// key_debounce_onehot
// Turns N_KEYS raw push-buttons into a clean one-hot key vector. Each
// channel is synchronized and debounced; a lock FSM then grabs the lowest
// held key and keeps it until that key is released, inserting at least one
// all-zero cycle between consecutive keys.
// Parameters: N_KEYS, DB_CYCLES (>= 2), SYNC_STAGES (>= 2).
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : key_debounce_onehot_if slave (btn_raw in; key_onehot, key_valid,
//         key_press, key_release out, all registered)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no key owned; key_onehot = 0; selects lowest debounced key
// ST_HELD | key 'owner' owned; outputs frozen until db[owner] drops

module key_debounce_onehot
  import key_debounce_onehot_pkg::*;
#(
  parameter int N_KEYS      = N_KEYS_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  key_debounce_onehot_if.slave  bus
);

  localparam int OWNER_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  logic [N_KEYS-1:0] db;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    btn_debounce #(
      .DB_CYCLES   (DB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (bus.btn_raw[i]),
      .db      (db[i])
    );
  end

  // Lowest set index wins; loop runs high to low so the last hit is lowest.
  logic [OWNER_W-1:0] pick_idx;
  logic               pick_any;

  always_comb begin
    pick_idx = '0;
    pick_any = |db;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (db[i]) pick_idx = OWNER_W'(i);
    end
  end

  state_t             state;
  logic [OWNER_W-1:0] owner;
  logic [N_KEYS-1:0]  onehot_q;
  logic               valid_q;
  logic               press_q;
  logic               release_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner    <= pick_idx;
            onehot_q <= N_KEYS'(1) << pick_idx;
            valid_q  <= 1'b1;
            press_q  <= 1'b1;
            state    <= ST_HELD;
          end
        end
        ST_HELD: begin
          // Other channels are ignored here; only the owner can end the hold.
          if (!db[owner]) begin
            onehot_q  <= '0;
            valid_q   <= 1'b0;
            release_q <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          onehot_q <= '0;
          valid_q  <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.key_onehot  = onehot_q;
  assign bus.key_valid   = valid_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;

endmodule

// File: tb/tb_key_debounce_onehot.sv
// tb_key_debounce_onehot
// Directed stimulus with a scoreboard queue of expected press/release
// events; a monitor pops and checks them and tracks the expected key vector.

module tb_key_debounce_onehot;
  import key_debounce_onehot_pkg::*;

  localparam int LAT = 7; // 2 sync + 4 debounce + 1 FSM edge

  typedef struct {
    int         at;
    bit         is_press;
    logic [6:0] onehot;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  logic rst_at_edge;
  int   total;
  int   bad;
  ev_t  exp_q[$];
  ev_t  e;
  logic [6:0] cur_exp;

  key_debounce_onehot_if #(.N_KEYS(7)) bus ();

  key_debounce_onehot #(
    .N_KEYS      (7),
    .DB_CYCLES   (DB_CYCLES_SIM),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc         = 0;
    rst_at_edge = 1'b1;
    total       = 0;
    bad         = 0;
    cur_exp     = '0;
  end

  always @(posedge clk) begin
    cyc         = cyc + 1;
    rst_at_edge = rst;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic expect_ev(input int at, input bit p, input logic [6:0] oh);
    ev_t x;
    x.at       = at;
    x.is_press = p;
    x.onehot   = oh;
    exp_q.push_back(x);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got no event, want press=%0b onehot=%b at cycle %0d",
               e.is_press, e.onehot, e.at);
    end
    if (rst_at_edge) begin
      cur_exp = '0;
      total++;
      if (bus.key_onehot !== 7'b0 || bus.key_valid !== 1'b0 ||
          bus.key_press !== 1'b0 || bus.key_release !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs @%0d: got onehot=%b valid=%b press=%b release=%b, want all 0",
                 cyc, bus.key_onehot, bus.key_valid, bus.key_press, bus.key_release);
      end
    end else begin
      if (bus.key_press !== 1'b0 || bus.key_release !== 1'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event @%0d: got press=%b release=%b onehot=%b, want no event",
                   cyc, bus.key_press, bus.key_release, bus.key_onehot);
        end else begin
          e = exp_q.pop_front();
          if (e.at != cyc || bus.key_press !== e.is_press ||
              bus.key_release !== !e.is_press || bus.key_onehot !== e.onehot) begin
            bad++;
            $display("FAIL event @%0d: got press=%b release=%b onehot=%b, want press=%0b release=%0b onehot=%b at cycle %0d",
                     cyc, bus.key_press, bus.key_release, bus.key_onehot,
                     e.is_press, !e.is_press, e.onehot, e.at);
          end
          cur_exp = e.onehot;
        end
      end
      total++;
      if (bus.key_onehot !== cur_exp || bus.key_valid !== (|cur_exp)) begin
        bad++;
        $display("FAIL key_state @%0d: got onehot=%b valid=%b, want onehot=%b valid=%b",
                 cyc, bus.key_onehot, bus.key_valid, cur_exp, |cur_exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.btn_raw = 7'b0000100;

    // 1: button held through reset, detected LAT edges after deassert
    tick(3);
    rst = 1'b0;
    expect_ev(cyc + LAT, 1'b1, 7'b0000100);
    tick(12);
    bus.btn_raw = 7'b0000000;
    expect_ev(cyc + LAT, 1'b0, 7'b0000000);
    tick(12);

    // 2: clean press/release of key 0
    bus.btn_raw = 7'b0000001;
    expect_ev(cyc + LAT, 1'b1, 7'b0000001);
    tick(12);
    bus.btn_raw = 7'b0000000;
    expect_ev(cyc + LAT, 1'b0, 7'b0000000);
    tick(12);

    // 3: bouncing key 3, then stable
    for (int k = 0; k < 10; k++) begin
      bus.btn_raw = (k % 2 == 0) ? 7'b0001000 : 7'b0000000;
      tick(1);
    end
    bus.btn_raw = 7'b0001000;
    expect_ev(cyc + LAT, 1'b1, 7'b0001000);
    tick(12);
    bus.btn_raw = 7'b0000000;
    expect_ev(cyc + LAT, 1'b0, 7'b0000000);
    tick(12);

    // 3b: 3-cycle glitch rejected, 4-cycle pulse accepted
    bus.btn_raw = 7'b0000010;
    tick(3);
    bus.btn_raw = 7'b0000000;
    tick(12);
    bus.btn_raw = 7'b0100000;
    expect_ev(cyc + LAT, 1'b1, 7'b0100000);
    tick(4);
    bus.btn_raw = 7'b0000000;
    expect_ev(cyc + LAT, 1'b0, 7'b0000000);
    tick(12);

    // 4: simultaneous keys 1 and 6; handover after key 1 released
    bus.btn_raw = 7'b1000010;
    expect_ev(cyc + LAT, 1'b1, 7'b0000010);
    tick(12);
    bus.btn_raw = 7'b1000000;
    expect_ev(cyc + LAT, 1'b0, 7'b0000000);
    expect_ev(cyc + LAT + 1, 1'b1, 7'b1000000);
    tick(12);
    bus.btn_raw = 7'b0000000;
    expect_ev(cyc + LAT, 1'b0, 7'b0000000);
    tick(12);

    // 5: key 2 pressed while key 5 held is ignored until key 5 released
    bus.btn_raw = 7'b0100000;
    expect_ev(cyc + LAT, 1'b1, 7'b0100000);
    tick(10);
    bus.btn_raw = 7'b0100100;
    tick(12);
    bus.btn_raw = 7'b0000100;
    expect_ev(cyc + LAT, 1'b0, 7'b0000000);
    expect_ev(cyc + LAT + 1, 1'b1, 7'b0000100);
    tick(12);
    bus.btn_raw = 7'b0000000;
    expect_ev(cyc + LAT, 1'b0, 7'b0000000);
    tick(12);

    // 6: reset while held on key 4; no release, fresh press afterwards
    bus.btn_raw = 7'b0010000;
    expect_ev(cyc + LAT, 1'b1, 7'b0010000);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_ev(cyc + LAT, 1'b1, 7'b0010000);
    tick(12);
    bus.btn_raw = 7'b0000000;
    expect_ev(cyc + LAT, 1'b0, 7'b0000000);
    tick(12);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL leftover_event: got no event, want press=%0b onehot=%b at cycle %0d",
               e.is_press, e.onehot, e.at);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
